// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared widths, lock states and helpers for the video timing receiver
package video_timing_pkg;
    localparam int CNT_W = 12;
    localparam logic [CNT_W-1:0] CNT_MAX = 12'd4095;
    localparam logic [CNT_W-1:0] REF_H_TOTAL = 12'd800;
    localparam logic [CNT_W-1:0] REF_H_ACTIVE = 12'd640;
    localparam logic [CNT_W-1:0] REF_V_TOTAL = 12'd525;
    localparam logic [CNT_W-1:0] REF_V_ACTIVE = 12'd480;
    typedef enum logic [1:0] {NOSIG, SEARCH, LOCKED} lock_state_t;
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction
    function automatic logic meas_ok(input logic [CNT_W-1:0] v);
        return (v != '0) && (v != CNT_MAX);
    endfunction
endpackage

// File: rtl/vt_edge_det.sv
// vt_edge_det: one-clock delay register with detection of the transition into the active level
module vt_edge_det #(
    parameter logic POL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q,
    output logic o_edge
);
    logic r_q;
    // previous-cycle sample, also serves as the delayed copy of the input
    always_ff @(posedge clk or posedge rst)
        if (rst) r_q <= 1'b0;
        else r_q <= i_d;
    assign o_q = r_q;
    assign o_edge = (i_d == POL) && (r_q != POL);
endmodule

// File: rtl/video_timing_rx.sv
// video_timing_rx: raster position tracking, timing measurement and lock detection
module video_timing_rx
    import video_timing_pkg::*;
#(
    parameter logic        HS_POL = 1'b0,
    parameter logic        VS_POL = 1'b0,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_hs_in,
    input  logic             i_vs_in,
    input  logic             i_de_in,
    output logic             o_hs_out,
    output logic             o_vs_out,
    output logic             o_de_out,
    output logic [CNT_W-1:0] o_x,
    output logic [CNT_W-1:0] o_y,
    output logic             o_sof,
    output logic [CNT_W-1:0] o_h_total,
    output logic [CNT_W-1:0] o_h_active,
    output logic [CNT_W-1:0] o_v_total,
    output logic [CNT_W-1:0] o_v_active,
    output logic             o_locked
);
    localparam logic [3:0] LF = 4'(LOCK_FRAMES);

    logic w_hs_edge, w_vs_edge, w_de_rise, w_de_fall, w_de_q;
    logic w_new_frame, w_timeout, w_match;
    logic [CNT_W-1:0] w_h_total_nx, w_h_active_nx;
    logic [CNT_W-1:0] r_x, r_y, r_clk_cnt, r_run_cnt, r_line_cnt, r_de_cnt;
    logic [CNT_W-1:0] r_h_total, r_h_active, r_v_total, r_v_active, r_h_snap, r_ha_snap;
    logic r_sof, r_first;
    logic [3:0] r_match_cnt, w_match_cnt_nx;
    lock_state_t r_state, w_state_nx;

    vt_edge_det #(.POL(HS_POL)) u_hs (.clk(clk), .rst(rst), .i_d(i_hs_in), .o_q(o_hs_out), .o_edge(w_hs_edge));
    vt_edge_det #(.POL(VS_POL)) u_vs (.clk(clk), .rst(rst), .i_d(i_vs_in), .o_q(o_vs_out), .o_edge(w_vs_edge));
    vt_edge_det #(.POL(1'b1))   u_de (.clk(clk), .rst(rst), .i_d(i_de_in), .o_q(w_de_q),   .o_edge(w_de_rise));

    assign w_de_fall = !i_de_in && w_de_q;
    assign w_new_frame = r_first || w_vs_edge;
    assign w_timeout = (r_clk_cnt == CNT_MAX);
    assign w_h_total_nx = w_hs_edge ? r_clk_cnt : r_h_total;
    assign w_h_active_nx = w_de_fall ? r_run_cnt : r_h_active;
    assign w_match = (w_h_total_nx == r_h_snap) && (w_h_active_nx == r_ha_snap)
                  && (r_line_cnt == r_v_total) && (r_de_cnt == r_v_active)
                  && meas_ok(w_h_total_nx) && meas_ok(w_h_active_nx)
                  && meas_ok(r_line_cnt) && meas_ok(r_de_cnt);

    // pixel column/row and start-of-frame, one clock behind the input they describe
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
            r_sof <= 1'b0;
            r_first <= 1'b0;
        end else begin
            r_x <= w_de_rise ? '0 : i_de_in ? sat_inc(r_x) : r_x;
            r_y <= w_de_rise ? (w_new_frame ? '0 : sat_inc(r_y)) : r_y;
            r_sof <= w_de_rise && w_new_frame;
            r_first <= w_de_rise ? 1'b0 : (w_vs_edge ? 1'b1 : r_first);
        end

    // free-running raster counters; a sync edge coincident with vs belongs to the new frame
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_clk_cnt <= '0;
            r_run_cnt <= '0;
            r_line_cnt <= '0;
            r_de_cnt <= '0;
        end else begin
            r_clk_cnt <= w_hs_edge ? CNT_W'(1) : sat_inc(r_clk_cnt);
            r_run_cnt <= i_de_in ? (w_de_rise ? CNT_W'(1) : sat_inc(r_run_cnt)) : '0;
            r_line_cnt <= w_vs_edge ? (w_hs_edge ? CNT_W'(1) : '0) : (w_hs_edge ? sat_inc(r_line_cnt) : r_line_cnt);
            r_de_cnt <= w_vs_edge ? (w_de_rise ? CNT_W'(1) : '0) : (w_de_rise ? sat_inc(r_de_cnt) : r_de_cnt);
        end

    // measurement latches plus per-frame snapshots of the horizontal values for frame matching
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_h_total <= '0;
            r_h_active <= '0;
            r_v_total <= '0;
            r_v_active <= '0;
            r_h_snap <= '0;
            r_ha_snap <= '0;
        end else if (w_timeout) begin
            r_h_total <= '0;
            r_h_active <= '0;
            r_v_total <= '0;
            r_v_active <= '0;
            r_h_snap <= '0;
            r_ha_snap <= '0;
        end else begin
            r_h_total <= w_h_total_nx;
            r_h_active <= w_h_active_nx;
            if (w_vs_edge) begin
                r_v_total <= r_line_cnt;
                r_v_active <= r_de_cnt;
                r_h_snap <= w_h_total_nx;
                r_ha_snap <= w_h_active_nx;
            end
        end

    // lock state and consecutive-match counter registers
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state <= NOSIG;
            r_match_cnt <= '0;
        end else begin
            r_state <= w_state_nx;
            r_match_cnt <= w_match_cnt_nx;
        end

    // lock next-state: timeout overrides everything, otherwise frames are judged at vs edges
    always_comb begin
        w_state_nx = r_state;
        w_match_cnt_nx = r_match_cnt;
        if (w_timeout) begin
            w_state_nx = NOSIG;
            w_match_cnt_nx = '0;
        end else begin
            if (w_vs_edge)
                w_match_cnt_nx = w_match ? ((r_match_cnt == 4'hF) ? r_match_cnt : r_match_cnt + 4'd1) : 4'd0;
            case (r_state)
                NOSIG:   if (w_hs_edge) w_state_nx = SEARCH;
                SEARCH:  if (w_vs_edge && w_match && (w_match_cnt_nx >= LF)) w_state_nx = LOCKED;
                LOCKED:  if (w_vs_edge && !w_match) w_state_nx = SEARCH;
                default: w_state_nx = NOSIG;
            endcase
        end
    end

    assign o_de_out = w_de_q;
    assign o_x = r_x;
    assign o_y = r_y;
    assign o_sof = r_sof;
    assign o_h_total = r_h_total;
    assign o_h_active = r_h_active;
    assign o_v_total = r_v_total;
    assign o_v_active = r_v_active;
    assign o_locked = (r_state == LOCKED);
endmodule

// File: doc/video_timing_rx.md
VIDEO_TIMING_RX -- requirements
Module: video_timing_rx

Interface
REQ-001 Parameter HS_POL, default 1'b0: input hs level that marks an active sync pulse.
REQ-002 Parameter VS_POL, default 1'b0: input vs level that marks an active sync pulse.
REQ-003 Parameter LOCK_FRAMES, default 2: number of consecutive matching frame measurements required for lock, range 1..15.
REQ-004 clk  input  1  pixel clock; all logic is on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 hs_in, vs_in, de_in  input  1 each  incoming raster sync and data-enable, synchronous to clk.
REQ-007 hs_out, vs_out, de_out  output  1 each  inputs delayed by exactly 1 clk.
REQ-008 x, y  output  12 each  active pixel column and row, aligned with de_out.
REQ-009 sof  output  1  one-cycle pulse with de_out when x=0 and y=0.
REQ-010 h_total, h_active, v_total, v_active  output  12 each  measured clocks/line, active pixels/line, lines/frame, active lines/frame.
REQ-011 locked  output  1  timing is stable.

Function
REQ-012 Sync edges: hs_edge = hs_in equals HS_POL this cycle and did not the previous cycle; vs_edge is the same using VS_POL; de_rise/de_fall use de_in transitions.
REQ-013 x: de_rise -> 0; de_in high and not de_rise -> x+1, saturating at 4095; holds while de_in low.
REQ-014 y: vs_edge sets a first-line flag. On de_rise: if the flag is set, y<=0 and the flag clears; otherwise y<=y+1, saturating at 4095.
REQ-015 Latency: x, y, sof and de_out are registered and appear 1 clk after the de_in cycle they describe.
REQ-016 clk_cnt: on hs_edge, h_total<=clk_cnt and clk_cnt<=1; otherwise clk_cnt+1, saturating at 4095.
REQ-017 run_cnt counts consecutive de_in-high cycles; on de_fall, h_active<=run_cnt.
REQ-018 line_cnt increments on hs_edge and de_cnt increments on de_rise, both saturating at 4095.
REQ-019 On vs_edge: v_total<=line_cnt and v_active<=de_cnt; de_cnt<=0. line_cnt<=1 if hs_edge occurs in the same cycle, otherwise 0. A coincident hs_edge belongs to the new frame.
REQ-020 Worked example: 800x525 timing with vs edges coincident with hs edges measures h_total=800 and v_total=525.
REQ-021 Lock FSM has states NOSIG, SEARCH and LOCKED; reset enters NOSIG.
REQ-022 A frame matches when, at vs_edge, all four new measurements equal the previously latched ones, are nonzero and are not 4095.
REQ-023 Match counter:
- on each vs_edge, a match increments it and a mismatch clears it to 0;
- reaching LOCK_FRAMES moves SEARCH to LOCKED;
- any mismatch in LOCKED moves to SEARCH.
REQ-024 locked=1 only in LOCKED.
REQ-025 NOSIG -> SEARCH on the first hs_edge.
REQ-026 Timeout: clk_cnt reaching 4095 in any state forces NOSIG, clears the four measurements and the match counter, and deasserts locked in the same cycle as the transition.
REQ-027 When vs_edge and de_rise coincide, vs_edge is processed first, so the new row is y=0.

Reset
REQ-028 During rst, all outputs and counters are 0, the first-line flag is clear and the FSM is in NOSIG.
REQ-029 Reset mid-frame discards partial measurements. Lock requires LOCK_FRAMES+1 complete frames after the first vs_edge following reset release.

Structure
REQ-030 Package video_timing_pkg holds CNT_W=12, CNT_MAX=4095, the FSM state enumeration, and 640x480 reference constants (800/640/525/480).
REQ-031 One sub-module, vt_edge_det: a parameterised-polarity 1-bit register plus edge detect, instantiated for hs, vs and de.

Verification
REQ-032 Standard 640x480 stream (FP/SYNC/BP 16/96/48, 10/2/33, both polarities low) -> after the 4th vs_edge: locked=1, h_total=800, h_active=640, v_total=525, v_active=480; x spans 0..639, y spans 0..479, one sof per frame.
REQ-033 Same stream with inverted syncs and HS_POL=VS_POL=1 -> identical measurements and lock.
REQ-034 While locked, change H_FP to 20 for one frame -> locked drops at the next vs_edge and h_total=804; after restoring the timing, locked returns after LOCK_FRAMES matching frames.
REQ-035 While locked, hold hs_in inactive for 4100 clks -> locked=0 and all measurements 0 once clk_cnt reaches 4095; resuming the stream relocks.
REQ-036 Assert rst for 3 clks mid-frame at line 200 -> all outputs 0 during reset; locked=1 again exactly at the 4th vs_edge after release.
REQ-037 vs_edge coincident with de_rise -> that line reports y=0, and sof is asserted with x=0.
